limit_dispatch_controller: RTL

LIMIT_DISPATCH_CONTROLLER -- requirements
Module: limit_dispatch_controller

---
 rtl/limit_dispatch_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/limit_dispatch_controller.sv
// Sequences CHANNELS single-precision operands through a downstream float unit, one at a time,
// and collects the results. Optional WAIT timeout enabled by defining LIMIT_DISPATCH_TIMEOUT_EN.
module limit_dispatch_controller #(
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CHANNELS*32-1:0] x_vec,
    output logic                  busy,
    output logic                  done,
    output logic [CHANNELS*32-1:0] y_vec,
    output logic [CHANNELS-1:0]   sat_flags,
    output logic                  err,
    output logic                  m_sta,
    output logic [31:0]           m_x,
    input  logic [31:0]           m_y,
    input  logic                  m_done
);

    localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CHANNELS*32-1:0] x_q, x_d;
    logic [CHANNELS*32-1:0] y_q, y_d;
    logic [CHANNELS-1:0]   sat_q, sat_d;

    logic [31:0] op_k;
    logic [31:0] cap_val;
    logic        timeout;
    logic        capture;
    logic        last_ch;

    assign op_k    = x_q[32*k_q +: 32];
    assign last_ch = (k_q == KW'(CHANNELS - 1));
    // A timed-out channel captures its own operand, so its sat flag naturally comes out 0.
    assign cap_val = m_done ? m_y : op_k;
    assign capture = (state_q == S_WAIT) && (m_done || timeout);

`ifdef LIMIT_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;

    // Expires at the end of the TIMEOUT-th WAIT cycle; a coincident m_done wins.
    assign timeout = (state_q == S_WAIT) && !m_done && (wait_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
        err_d      = err_q;
        if (state_q == S_IDLE && start) begin
            err_d = 1'b0;
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first; a path that misses an assignment would otherwise infer a latch.
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_vec;
                    sat_d   = '0;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (capture) begin
                    y_d[32*k_q +: 32] = cap_val;
                    sat_d[k_q]        = (cap_val != op_k);
                    if (last_ch) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: result registers are reset too, because y_vec/sat_flags are visible outputs that must read 0 after reset.
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sat_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign m_sta     = (state_q == S_ISSUE);
    assign m_x       = (state_q == S_ISSUE || state_q == S_WAIT) ? op_k : 32'h0;
    assign y_vec     = y_q;
    assign sat_flags = sat_q;

endmodule
